// File: rtl/rtu_tile_scheduler_if.sv
// Bus bundle between the tile requesters / transform unit / output memory
// and the tile scheduler.
//
// Handshake rules:
//   req[r] is raised with tile_in[r] stable and held until grant[r] pulses
//   for one cycle; grant[r] is the only acceptance indication. rtu_start is
//   a one-cycle launch pulse with rtu_matrix valid from that cycle until the
//   next launch; rtu_done is a one-cycle pulse with rtu_result valid in the
//   same cycle. wr_en qualifies wr_addr/wr_data per cycle, no backpressure.
interface rtu_tile_scheduler_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic [1:0]                         req;
    logic [1:0][5:0][5:0][DATA_W-1:0]   tile_in;
    logic                               frame_clear;
    logic [1:0]                         grant;
    logic                               rtu_start;
    logic [5:0][5:0][DATA_W-1:0]        rtu_matrix;
    logic                               rtu_done;
    logic [3:0][3:0][DATA_W-1:0]        rtu_result;
    logic                               wr_en;
    logic [ADDR_W-1:0]                  wr_addr;
    logic [DATA_W-1:0]                  wr_data;
    logic                               busy;
    logic [1:0]                         frame_done;
    logic [1:0]                         state_dbg;

    // Environment side: requesters, transform unit and memory observer.
    modport master (
        output req, tile_in, frame_clear, rtu_done, rtu_result,
        input  grant, rtu_start, rtu_matrix, wr_en, wr_addr, wr_data,
               busy, frame_done, state_dbg
    );

    // Scheduler side.
    modport slave (
        input  req, tile_in, frame_clear, rtu_done, rtu_result,
        output grant, rtu_start, rtu_matrix, wr_en, wr_addr, wr_data,
               busy, frame_done, state_dbg
    );
endinterface

// File: rtl/rtu_tile_scheduler.sv
// Tile scheduler: round-robin arbitration between two 6x6 tile requesters,
// launches the transform unit on the granted tile, then streams the 4x4
// result into a two-plane output memory at the requester's current tile
// position, tracking per-requester tile counters and frame completion.
module rtu_tile_scheduler #(
    parameter int DATA_W  = 16,
    parameter int TILES_X = 4,
    parameter int TILES_Y = 4,
    parameter int ADDR_W  = 10
) (
    input  logic clk,
    input  logic rst_n,
    rtu_tile_scheduler_if.slave bus
);
    localparam int RS  = 4 * TILES_X;
    localparam int PS  = 16 * TILES_X * TILES_Y;
    localparam int TXW = (TILES_X > 1) ? $clog2(TILES_X) : 1;
    localparam int TYW = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
    localparam logic [TXW-1:0] TX_MAX = TXW'(TILES_X - 1);
    localparam logic [TYW-1:0] TY_MAX = TYW'(TILES_Y - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        WRITE  = 2'd3
    } state_t;

    state_t                      state;
    logic                        last_r;   // requester granted most recently
    logic                        src;      // requester owning the tile in flight
    logic [3:0]                  cnt;      // element currently on the write port
    logic [3:0]                  nxt;
    logic [1:0][TXW-1:0]         tx_cnt;
    logic [1:0][TYW-1:0]         ty_cnt;
    logic [3:0][3:0][DATA_W-1:0] res;
    logic                        sel_valid;
    logic                        sel_r;

    // Output-memory address of element e (row-major in the 4x4 result).
    function automatic logic [ADDR_W-1:0] calc_addr(
        input logic           r,
        input logic [TXW-1:0] tx,
        input logic [TYW-1:0] ty,
        input logic [3:0]     e
    );
        int a;
        a = int'(r) * PS + (int'(ty) * 4 + int'(e[3:2])) * RS
            + int'(tx) * 4 + int'(e[1:0]);
        return a[ADDR_W-1:0];
    endfunction

    assign nxt           = cnt + 4'd1;
    assign bus.busy      = (state != IDLE);
    assign bus.state_dbg = state;

    // Round-robin pick: on contention favour the requester not granted last.
    always_comb begin
        sel_valid = |bus.req;
        sel_r     = 1'b0;
        if (bus.req == 2'b11) sel_r = ~last_r;
        else                  sel_r = bus.req[1];
    end

    // Scheduler FSM with registered outputs and per-requester tile counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_r         <= 1'b1;
            src            <= 1'b0;
            cnt            <= '0;
            tx_cnt         <= '0;
            ty_cnt         <= '0;
            res            <= '0;
            bus.grant      <= '0;
            bus.rtu_start  <= 1'b0;
            bus.rtu_matrix <= '0;
            bus.wr_en      <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
            bus.frame_done <= '0;
        end else begin
            bus.grant      <= '0;
            bus.rtu_start  <= 1'b0;
            bus.frame_done <= '0;
            case (state)
                IDLE: begin
                    if (bus.frame_clear) begin
                        tx_cnt <= '0;
                        ty_cnt <= '0;
                        last_r <= 1'b1;
                    end else if (sel_valid) begin
                        src            <= sel_r;
                        last_r         <= sel_r;
                        bus.rtu_matrix <= bus.tile_in[sel_r];
                        bus.grant      <= sel_r ? 2'b10 : 2'b01;
                        bus.rtu_start  <= 1'b1;
                        state          <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.rtu_done) begin
                        res         <= bus.rtu_result;
                        cnt         <= '0;
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= calc_addr(src, tx_cnt[src], ty_cnt[src], 4'd0);
                        bus.wr_data <= bus.rtu_result[0][0];
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    if (cnt == 4'd15) begin
                        bus.wr_en <= 1'b0;
                        state     <= IDLE;
                        if (tx_cnt[src] == TX_MAX) begin
                            tx_cnt[src] <= '0;
                            if (ty_cnt[src] == TY_MAX) begin
                                ty_cnt[src]         <= '0;
                                bus.frame_done[src] <= 1'b1;
                            end else begin
                                ty_cnt[src] <= ty_cnt[src] + TYW'(1);
                            end
                        end else begin
                            tx_cnt[src] <= tx_cnt[src] + TXW'(1);
                        end
                    end else begin
                        cnt         <= nxt;
                        bus.wr_addr <= calc_addr(src, tx_cnt[src], ty_cnt[src], nxt);
                        bus.wr_data <= res[nxt[3:2]][nxt[1:0]];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/rtu_tile_scheduler.md
RTU_TILE_SCHEDULER -- requirements
Module: rtu_tile_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 16: element width.
REQ-002 SHALL have parameter TILES_X, default 4: output tiles per row; row stride RS = 4*TILES_X.
REQ-003 SHALL have parameter TILES_Y, default 4: tile rows per frame; plane size PS = 16*TILES_X*TILES_Y.
REQ-004 SHALL have parameter ADDR_W, default 10: write address width; must satisfy 2*PS <= 2^ADDR_W.
REQ-005 SHALL have port clk  in  1  clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req  in  2  per-requester "6x6 tile available", held until granted.
REQ-008 SHALL have port tile_in  in  2x6x6xDATA_W  per-requester tile, stable while req high.
REQ-009 SHALL have port frame_clear  in  1  clear tile counters and arbitration pointer.
REQ-010 SHALL have port grant  out  2  one-hot, one-cycle pulse: tile accepted.
REQ-011 SHALL have port rtu_start  out  1  one-cycle launch pulse to the transform unit.
REQ-012 SHALL have port rtu_matrix  out  6x6xDATA_W  registered copy of the granted tile.
REQ-013 SHALL have port rtu_done  in  1  transform-complete pulse.
REQ-014 SHALL have port rtu_result  in  4x4xDATA_W  transform result.
REQ-015 SHALL have port wr_en / wr_addr / wr_data  out  1 / ADDR_W / DATA_W  output-memory write port.
REQ-016 SHALL have port busy  out  1  high in every state except IDLE.
REQ-017 SHALL have port frame_done  out  2  per-requester one-cycle pulse: last tile of frame written.

Function
REQ-018 SHALL implement states IDLE, LAUNCH, WAIT, WRITE; transitions IDLE->LAUNCH (a req granted), LAUNCH->WAIT, WAIT->WRITE (rtu_done=1), WRITE->IDLE (after 16th write).
REQ-019 SHALL, in IDLE, arbitrate round-robin: with both requesters requesting, grant the one not granted last; after reset/frame_clear requester 0 has priority.
REQ-020 SHALL, on the IDLE edge that selects requester r, capture tile_in[r] into rtu_matrix and record r as the active source; grant[r] and rtu_start are high for exactly the LAUNCH cycle.
REQ-021 SHALL ignore rtu_done outside WAIT; in WAIT, capture rtu_result on the edge rtu_done=1 is sampled.
REQ-022 SHALL, in WRITE, emit 16 consecutive wr_en cycles, row-major element (i,j), i,j in 0..3, wr_data = captured result[i][j].
REQ-023 SHALL compute wr_addr = r*PS + (ty*4+i)*RS + tx*4 + j, truncated to ADDR_W, using requester r's tile counters (tx,ty).
REQ-024 SHALL, on the 16th write, advance r's counters: tx+1; at tx=TILES_X-1, tx->0 and ty+1; at (TILES_X-1,TILES_Y-1) wrap both to 0 and pulse frame_done[r] in the following cycle.
REQ-025 SHALL honour frame_clear only in IDLE, taking priority over req (no grant that cycle); frame_clear in other states is ignored.
REQ-026 SHALL give timing relative to the sampling edge in IDLE = cycle 0 with a 3-cycle transform: grant/rtu_start cycle 1, rtu_done cycle 5, writes cycles 6-21, IDLE cycle 22, next grant no earlier than cycle 23.
REQ-027 SHALL hold wr_en, grant, rtu_start, frame_done low whenever not specified high.

Reset
REQ-028 SHALL, on rst_n low, asynchronously enter IDLE, clear all counters, pointer, rtu_matrix, captured result, and drive all outputs 0; an in-flight tile is discarded and no partial write continues.

Verification
REQ-029 Single tile: req=01, tile_in[0] M[0][0]=1 else 0 -> grant=01 cycle 1; writes addr 0 data 1, then addrs 1,2,3,16,17,18,19,32..35,48..51 data 0.
REQ-030 Contention: req=11 from reset -> grant 01 first, then 10; requester 1 first tile writes addrs 256..259,272..275,...,304..307.
REQ-031 Frame wrap: 16 tiles from requester 0 -> 16th tile writes addrs 204..207,...,252..255; frame_done=01 once; 17th tile writes addr 0 again.
REQ-032 Late done: hold rtu_done low 10 extra cycles -> FSM stays WAIT, no wr_en, busy=1; writes start cycle after done.
REQ-033 frame_clear with req=01 in IDLE -> no grant that cycle, counters 0; frame_clear during WRITE -> ignored, addresses continue.
REQ-034 rst_n low at 8th write -> wr_en=0 immediately, busy=0; next tile after reset writes from addr 0.
